// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: valid/ready handshake, optional
// two-entry skid buffer, synchronous flush that leaves a FLUSH_VAL bubble.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 96,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, consume;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid_q & out_ready;

  // With a skid entry in_ready comes straight from a flop; without one it
  // must see out_ready so a full stage can still pass a word per cycle.
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = in_ready_q;
    end else begin : g_flow_ready
      assign in_ready = ~out_valid_q | out_ready;
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = 2'(state_q);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          main_d  = in_data;
        end
      end
      FULL: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = BUSY;
          skid_d  = in_data;
        end else if (consume) begin
          state_d = EMPTY;
          main_d  = FLUSH_VAL;
        end
      end
      BUSY: begin
        if (consume) begin
          state_d = FULL;
          main_d  = skid_q;
          skid_d  = FLUSH_VAL;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = FLUSH_VAL;
        skid_d  = FLUSH_VAL;
      end
    endcase
    // Flush overrides all handshake activity; a same-cycle consume has
    // already been seen downstream, an accepted input is simply dropped.
    if (flush) begin
      state_d = EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != BUSY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, elastic inter-stage pipeline register for the pipelined RISC-V datapath. It generalises the fixed fetch/decode register to any payload width. It replaces the enable/clear pair with a valid/ready handshake, an optional skid entry and a synchronous flush. It is instantiated between any two datapath stages, for example IF/ID, ID/EX, EX/MEM or MEM/WB.

Parameters:
WIDTH, 96, payload width in bits (IF/ID: Instr+PC+PCPlus4).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
FLUSH_VAL, {WIDTH{1'b0}}, value driven on out_data after reset/flush (zero = NOP-equivalent bubble).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear; discards all held and incoming entries.
in_valid  input  1  upstream stage presents in_data.
in_ready  output  1  block can accept in_data this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  out_data holds a valid entry.
out_ready  input  1  downstream consumes out_data this cycle.
out_data  output  WIDTH  payload to downstream stage.
occupancy  output  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Accept = in_valid & in_ready; Consume = out_valid & out_ready. Both are evaluated on the same rising edge.
- Reset (async) values: out_valid=0, out_data=FLUSH_VAL, skid entry empty with skid data=FLUSH_VAL, occupancy=0. in_ready=1 when SKID=1.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle). The path is never combinational from in_data to out_data.
- Ordering: strict FIFO; no entry is duplicated or dropped except by flush.
- SKID=1 state machine (state register encodes occupancy):
  - EMPTY: Accept -> FULL, main<=in_data. Otherwise stay EMPTY.
  - FULL: Accept&Consume -> FULL, main<=in_data. Accept&!Consume -> BUSY, skid<=in_data. !Accept&Consume -> EMPTY, main<=FLUSH_VAL. Neither -> hold.
  - BUSY: in_ready=0. Consume -> FULL, main<=skid, skid<=FLUSH_VAL. Otherwise hold.
  - in_ready = (state != BUSY), driven directly from a flop or from state decode only; it has no dependence on out_ready.
- SKID=0:
  - in_ready = !out_valid | out_ready.
  - Accept loads main; Consume without Accept clears out_valid and sets out_data=FLUSH_VAL.
  - occupancy[1] = 0.
- Flush (synchronous), priority above all handshake activity:
  - At the flush edge, go to EMPTY and drive out_valid=0, out_data=FLUSH_VAL, skid=FLUSH_VAL.
  - An input accepted in the flush cycle is dropped.
  - A Consume in the flush cycle still completes for the downstream stage, since out_data was valid during that cycle.
- Flush and reset asserted together: reset wins; the result is the same state.
- Reset mid-operation: all entries are discarded immediately (async), with no partial update.
- Out_data while out_valid=0 is always FLUSH_VAL. A non-handshaking consumer therefore sees a bubble, which keeps legacy decode-stage logic safe.
- in_data is sampled only on Accept. out_data changes only on edges where Consume, Accept-into-main, skid promotion, flush or reset occurs.
- occupancy = 0, 1 or 2 for EMPTY, FULL or BUSY respectively.

Test Plan:
1. Reset, then in_valid=1 with in_data=0x...0100 and out_ready=1 on every cycle -> out_valid=1 one cycle later, out_data=0x...0100; streaming 0x100,0x104,0x108 emerges back-to-back with 1-cycle latency and occupancy=1.
2. SKID=1, out_ready=0, present A=0xA, B=0xB, C=0xC -> A and B accepted, occupancy=2, in_ready=0 with C held upstream. Raise out_ready -> outputs A, B, C in order, with no loss and no duplication.
3. Occupancy=2 (A in main, B in skid), flush=1 for one cycle with in_valid=1 and D=0xD -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; D never appears.
4. SKID=0, out_valid=1, out_ready=1, in_valid=1 on the same edge -> in_ready=1 and the new word replaces the old in one cycle. With out_ready=0 -> in_ready=0 and out_data is held.
5. Assert reset asynchronously mid-cycle while occupancy=2 -> out_valid drops before the next edge, out_data=FLUSH_VAL, and occupancy=0.
6. Randomised valid/ready over 10k cycles at WIDTH=32 and WIDTH=160 -> the scoreboard matches the input sequence exactly, in_ready never depends combinationally on out_ready when SKID=1, and occupancy stays ≤ 2.
